// File: rtl/argmax_controller.sv
// Arg-max controller: collects one frame of unsigned class scores over a valid/ready stream
// and reports the winning index and value, flagging short or unterminated frames.
module argmax_controller #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned IDX_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    input  logic              score_valid,
    output logic              score_ready,
    input  logic [DATA_W-1:0] score_data,
    input  logic              score_last,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [IDX_W-1:0]  max_index,
    output logic [DATA_W-1:0] max_value,
    output logic              frame_error
);

    typedef enum logic [1:0] {StIdle, StCollect, StResult} state_t;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CLASSES - 1);

    state_t           state_q;
    logic [IDX_W-1:0] beat_cnt_q;
    logic             accept;
    logic             at_last_idx;
    logic             frame_end;

    assign accept      = score_valid && score_ready;
    assign at_last_idx = (beat_cnt_q == LastIdx);
    assign frame_end   = at_last_idx || score_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            busy         <= 1'b0;
            score_ready  <= 1'b0;
            result_valid <= 1'b0;
            frame_error  <= 1'b0;
            max_index    <= '0;
            max_value    <= '0;
            beat_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StCollect;
                        busy        <= 1'b1;
                        score_ready <= 1'b1;
                        beat_cnt_q  <= '0;
                        frame_error <= 1'b0;
                    end
                end
                StCollect: begin
                    if (accept) begin
                        // Strict compare keeps the lowest index on ties.
                        if (beat_cnt_q == '0 || score_data > max_value) begin
                            max_value <= score_data;
                            max_index <= beat_cnt_q;
                        end
                        beat_cnt_q <= beat_cnt_q + IDX_W'(1);
                        if (frame_end) begin
                            state_q      <= StResult;
                            score_ready  <= 1'b0;
                            result_valid <= 1'b1;
                            // Short frame or missing last marker: exactly one of the two holds.
                            frame_error  <= score_last ^ at_last_idx;
                        end
                    end
                end
                StResult: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        if (start) begin
                            state_q     <= StCollect;
                            score_ready <= 1'b1;
                            beat_cnt_q  <= '0;
                            frame_error <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_controller.sv
// Self-checking bench for argmax_controller: expected results are queued as frames are
// driven and compared when the controller presents each result.
module tb_argmax_controller;

    localparam int unsigned NC     = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 4;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] val;
        logic              err;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              score_valid;
    logic              score_ready;
    logic [DATA_W-1:0] score_data;
    logic              score_last;
    logic              result_valid;
    logic              result_ready;
    logic [IDX_W-1:0]  max_index;
    logic [DATA_W-1:0] max_value;
    logic              frame_error;

    exp_t              sb[$];
    logic [DATA_W-1:0] beats[NC];
    int                n_checks;
    int                n_fail;

    argmax_controller #(
        .NUM_CLASSES(NC),
        .DATA_W     (DATA_W),
        .IDX_W      (IDX_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .score_valid (score_valid),
        .score_ready (score_ready),
        .score_data  (score_data),
        .score_last  (score_last),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .max_index   (max_index),
        .max_value   (max_value),
        .frame_error (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame from beats[]; last_at < 0 means no last marker is sent.
    task automatic send_frame(input int last_at, input bit stall, input bit do_start,
                              input int mid_start_at);
        int                fin;
        int                k;
        int                cyc;
        int                acc;
        bit                v;
        logic [DATA_W-1:0] mv;
        logic [IDX_W-1:0]  mi;
        exp_t              e;
        fin = (last_at >= 0 && last_at < int'(NC) - 1) ? last_at : int'(NC) - 1;
        mv  = beats[0];
        mi  = '0;
        for (int i = 1; i <= fin; i++) begin
            if (beats[i] > mv) begin
                mv = beats[i];
                mi = IDX_W'(i);
            end
        end
        e.idx = mi;
        e.val = mv;
        e.err = (last_at != int'(NC) - 1);
        sb.push_back(e);
        if (do_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        k   = 0;
        cyc = 0;
        acc = 0;
        v   = 1'b0;
        while (k <= fin && cyc < 100) begin
            v           = stall ? ~v : 1'b1;
            score_valid = v;
            score_data  = beats[k];
            score_last  = (k == last_at);
            start       = (k == mid_start_at) && v;
            if (v && score_ready) begin
                acc++;
                k++;
            end
            step();
            cyc++;
        end
        score_valid = 1'b0;
        score_last  = 1'b0;
        start       = 1'b0;
        check_eq("beats_accepted", 64'(acc), 64'(fin + 1));
        check_eq("latency_result_valid", 64'(result_valid), 64'(1));
        check_eq("ready_low_in_result", 64'(score_ready), 64'(0));
    endtask

    task automatic take_result(input int hold, input bit restart);
        int   guard;
        exp_t e;
        guard = 0;
        while (!result_valid && guard < 20) begin
            step();
            guard++;
        end
        check_eq("result_valid_seen", 64'(result_valid), 64'(1));
        check_eq("scoreboard_nonempty", 64'(sb.size() > 0), 64'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("max_index", 64'(max_index), 64'(e.idx));
            check_eq("max_value", 64'(max_value), 64'(e.val));
            check_eq("frame_error", 64'(frame_error), 64'(e.err));
            for (int h = 0; h < hold; h++) begin
                score_valid = 1'b1;
                score_data  = '1;
                step();
                check_eq("hold_result_valid", 64'(result_valid), 64'(1));
                check_eq("hold_score_ready", 64'(score_ready), 64'(0));
                check_eq("hold_max_index", 64'(max_index), 64'(e.idx));
                check_eq("hold_max_value", 64'(max_value), 64'(e.val));
                check_eq("hold_frame_error", 64'(frame_error), 64'(e.err));
            end
            score_valid  = 1'b0;
            result_ready = 1'b1;
            start        = restart;
            step();
            result_ready = 1'b0;
            start        = 1'b0;
            check_eq("handshake_clears_valid", 64'(result_valid), 64'(0));
            check_eq("post_handshake_ready", 64'(score_ready), 64'(restart));
            check_eq("post_handshake_busy", 64'(busy), 64'(restart));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_busy"}, 64'(busy), 64'(0));
        check_eq({tag, "_score_ready"}, 64'(score_ready), 64'(0));
        check_eq({tag, "_result_valid"}, 64'(result_valid), 64'(0));
        check_eq({tag, "_max_index"}, 64'(max_index), 64'(0));
        check_eq({tag, "_max_value"}, 64'(max_value), 64'(0));
        check_eq({tag, "_frame_error"}, 64'(frame_error), 64'(0));
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        score_valid  = 1'b0;
        score_data   = '0;
        score_last   = 1'b0;
        result_ready = 1'b0;
        step();
        step();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        step();

        // Nominal frame, then a held result closed with a back-to-back start.
        beats = '{5, 9, 3, 12, 7, 1, 0, 11, 2, 4};
        send_frame(9, 1'b0, 1'b1, -1);
        take_result(5, 1'b1);

        // Tie at indices 1 and 2, stalled valid, ignored start mid-frame.
        beats = '{8, 20, 20, 3, 4, 5, 6, 7, 1, 2};
        send_frame(9, 1'b1, 1'b0, 3);
        take_result(0, 1'b0);

        for (int i = 0; i < int'(NC); i++) beats[i] = 32'h7FFF_FFFF;
        beats[9] = 32'hFFFF_FFFF;
        send_frame(9, 1'b0, 1'b1, -1);
        take_result(0, 1'b0);

        for (int i = 0; i < int'(NC); i++) beats[i] = '0;
        send_frame(9, 1'b0, 1'b1, -1);
        take_result(0, 1'b0);

        // Short frame: max must come from beats 0..5 only.
        beats = '{3, 50, 7, 50, 2, 9, 99, 100, 1, 1};
        send_frame(5, 1'b0, 1'b1, -1);
        take_result(0, 1'b0);

        beats = '{4, 4, 4, 4, 4, 4, 17, 4, 4, 4};
        send_frame(-1, 1'b0, 1'b1, -1);
        take_result(0, 1'b0);

        // Reset after beat 4 of a frame carrying a large score.
        beats = '{500, 600, 900, 700, 800, 1, 1, 1, 1, 1};
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            score_valid = 1'b1;
            score_data  = beats[k];
            step();
        end
        score_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        step();
        rst_n = 1'b1;
        step();
        check_zero_outputs("after_reset");

        beats = '{5, 9, 3, 12, 7, 1, 0, 11, 2, 4};
        send_frame(9, 1'b0, 1'b1, -1);
        take_result(0, 1'b0);

        check_eq("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/argmax_controller.md
Name: argmax_controller

Overview:
- Sequencing controller for class-score arg-max selection at the classifier output stage.
- Accepts one frame of NUM_CLASSES unsigned scores, streamed one per cycle over a valid/ready handshake, and tracks a running maximum as beats arrive.
- Presents the winning index and value over a result handshake, and flags malformed frames.
- Sits between the output-layer accumulator stream and downstream display/decision logic.

Parameters:
- NUM_CLASSES, 10, scores per frame; legal range 2..(2**IDX_W).
- DATA_W, 32, score width; scores are unsigned.
- IDX_W, 4, index/counter width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to open a new frame.
- busy  output  1  high in COLLECT and RESULT.
- score_valid  input  1  score_data is valid this cycle.
- score_ready  output  1  controller accepts a beat this cycle.
- score_data  input  DATA_W  class score; beat k carries class k.
- score_last  input  1  marks the final beat of a frame.
- result_valid  output  1  max_index, max_value and frame_error are valid.
- result_ready  input  1  consumer takes the result.
- max_index  output  IDX_W  index of the highest score.
- max_value  output  DATA_W  highest score.
- frame_error  output  1  frame length or last-marker mismatch.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE; busy, score_ready, result_valid, frame_error = 0; max_index=0; max_value=0; beat counter=0.
- States: IDLE, COLLECT, RESULT. score_ready is a registered decode of state==COLLECT. A beat is accepted when score_valid && score_ready.
- IDLE:
  - start=1 -> COLLECT next cycle; clear counter and frame_error.
  - max_index/max_value keep the previous result until the first beat of the new frame is accepted.
- COLLECT, accepted beat with counter value k:
  - k==0: max_value<=data, max_index<=0.
  - k>0: update only if data > max_value (strictly unsigned greater), so on a tie the lowest index wins.
  - counter increments by 1.
- End of frame:
  - Frame ends on the accepted beat where k==NUM_CLASSES-1 or score_last=1, whichever comes first; next state is RESULT.
  - frame_error<=1 if score_last=1 with k<NUM_CLASSES-1 (short frame), or k==NUM_CLASSES-1 with score_last=0 (missing last).
  - A short frame still reports the maximum over the beats received.
- Latency: result_valid rises the cycle after the last beat is accepted. score_ready drops in that same cycle, so no beat is accepted in RESULT.
- RESULT:
  - result_valid=1; max_index, max_value and frame_error are held stable until the handshake.
  - result_valid && result_ready -> IDLE.
  - If start=1 in the handshake cycle -> COLLECT directly (back-to-back frames).
- start while busy, outside the RESULT handshake cycle, is ignored. No queuing.
- score_valid in IDLE or RESULT is ignored (score_ready=0).
- Counter is IDX_W wide and never wraps within a frame; it is cleared on entry to COLLECT.
- Reset mid-frame or mid-result: immediate return to reset values; the partial frame is discarded.
- No combinational path from any input to any output.

Test Plan:
- Nominal: start, then scores 5,9,3,12,7,1,0,11,2,4 with last on beat 9 -> result_valid on the cycle after beat 9; max_index=3, max_value=12, frame_error=0.
- Tie and stall: scores 8,20,20,... with max 20 at indices 1 and 2, and score_valid toggled every other cycle -> max_index=1, max_value=20; accepted beats count exactly 10.
- Unsigned and extremes: 0xFFFFFFFF at index 9, all other beats 0x7FFFFFFF -> max_index=9, max_value=0xFFFFFFFF. Separately, all beats zero -> max_index=0, max_value=0.
- Framing errors:
  - score_last on beat 5 -> RESULT after 6 beats, frame_error=1, max taken over beats 0..5.
  - 10 beats with no score_last -> frame_error=1 with a correct maximum.
- Handshake: hold result_ready=0 for 5 cycles -> outputs stable, score_ready=0. Then result_ready=1 with start=1 in the same cycle -> next cycle COLLECT, score_ready=1. A start pulse mid-COLLECT is ignored.
- Reset: drive rst_n low after beat 4 -> outputs zero immediately. After release, a fresh start and a full frame produce the correct result, with no residue from the aborted frame.
